// File: rtl/maxfinder_frame_packer.sv
// rtl/maxfinder_frame_packer.sv - packs serial neuron results into one maxfinder input frame
// Beat k lands in slot k (LSB first); a completed frame is strobed for exactly one EMIT cycle.

module maxfinder_frame_packer #(
  parameter int INPUT_NUM  = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           neuron_data,
  input  logic                            neuron_valid,
  output logic                            neuron_ready,
  input  logic                            frame_clr,
  output logic [INPUT_NUM*DATA_WIDTH-1:0] data_out,
  output logic                            data_valid,
  output logic [$clog2(INPUT_NUM+1)-1:0]  beat_cnt
);

  localparam int CW = $clog2(INPUT_NUM + 1);
  localparam int FW = INPUT_NUM * DATA_WIDTH;

  typedef enum logic {COLLECT = 1'b0, EMIT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            accept;
  logic            last_beat;

  assign accept    = neuron_valid && neuron_ready;
  assign last_beat = (beat_cnt_q == CW'(INPUT_NUM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_clr) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (accept && last_beat) state_d = EMIT;
        EMIT:    state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Ready drops during reset as well, so upstream never sees a phantom accept.
  always_comb begin
    neuron_ready = (state_q == COLLECT) && !frame_clr && rst_n;
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    buf_d        = buf_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (frame_clr) begin
      beat_cnt_d = '0;
      buf_d      = '0;
    end else if (accept) begin
      if (last_beat) begin
        data_out_d = buf_q;
        data_out_d[(INPUT_NUM-1)*DATA_WIDTH +: DATA_WIDTH] = neuron_data;
        data_valid_d = 1'b1;
        beat_cnt_d   = '0;
        buf_d        = '0;
      end else begin
        for (int k = 0; k < INPUT_NUM - 1; k++) begin
          if (beat_cnt_q == CW'(k)) buf_d[k*DATA_WIDTH +: DATA_WIDTH] = neuron_data;
        end
        beat_cnt_d = beat_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      buf_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      buf_q        <= buf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_maxfinder_frame_packer.sv
// tb/tb_maxfinder_frame_packer.sv - self-checking bench for maxfinder_frame_packer
// Table vectors, directed corner sequences and random traffic against a queue-based model.

module tb_maxfinder_frame_packer;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int FW = N * DW;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] neuron_data = '0;
  logic          neuron_valid = 1'b0;
  logic          neuron_ready;
  logic          frame_clr = 1'b0;
  logic [FW-1:0] data_out;
  logic          data_valid;
  logic [CW-1:0] beat_cnt;

  maxfinder_frame_packer #(.INPUT_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .neuron_data  (neuron_data),
    .neuron_valid (neuron_valid),
    .neuron_ready (neuron_ready),
    .frame_clr    (frame_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .beat_cnt     (beat_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int pulses[$];

  // Reference: beats accepted so far in the open frame, last frame, and pending strobe.
  logic [DW-1:0] m_beats[$];
  logic [FW-1:0] m_out = '0;
  logic          m_emit = 1'b0;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          c;
    logic          exp_rdy;
    logic          exp_dv;
    logic [CW-1:0] exp_cnt;
    logic [FW-1:0] exp_out;
  } vec_t;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_out  = '0;
    m_emit = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic c);
    if (c) begin
      m_beats.delete();
      m_emit = 1'b0;
    end else if (m_emit) begin
      m_emit = 1'b0;
    end else if (v) begin
      m_beats.push_back(d);
      if (m_beats.size() == N) begin
        for (int k = 0; k < N; k++) m_out[k*DW +: DW] = m_beats[k];
        m_emit = 1'b1;
        m_beats.delete();
      end
    end
  endtask

  // Called at posedge+1: drive, check ready, cross the edge, check registered outputs.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic c, output logic rdy);
    neuron_valid = v;
    neuron_data  = d;
    frame_clr    = c;
    #1;
    rdy = neuron_ready;
    chk("neuron_ready", FW'(neuron_ready), FW'(!m_emit && !c));
    @(posedge clk);
    model_edge(v, d, c);
    cyc++;
    #1;
    chk("data_valid", FW'(data_valid), FW'(m_emit));
    chk("beat_cnt", FW'(beat_cnt), FW'(m_beats.size()));
    chk("data_out", data_out, m_out);
    if (data_valid) pulses.push_back(cyc);
  endtask

  vec_t tbl[9];
  logic rdy;
  logic [FW-1:0] f12345;

  initial begin
    f12345 = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    tbl[0] = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 3'd1, '0};
    tbl[1] = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 3'd2, '0};
    tbl[2] = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 3'd3, '0};
    tbl[3] = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 3'd4, '0};
    tbl[4] = '{1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 3'd0, f12345};
    tbl[5] = '{1'b1, 16'd6, 1'b0, 1'b0, 1'b0, 3'd0, f12345};
    tbl[6] = '{1'b1, 16'd6, 1'b0, 1'b1, 1'b0, 3'd1, f12345};
    tbl[7] = '{1'b1, 16'd7, 1'b1, 1'b0, 1'b0, 3'd0, f12345};
    tbl[8] = '{1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 3'd0, f12345};

    // Reset state
    #2;
    chk("rst_ready", FW'(neuron_ready), FW'(0));
    chk("rst_valid", FW'(data_valid), FW'(0));
    chk("rst_out", data_out, '0);
    chk("rst_cnt", FW'(beat_cnt), FW'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Table: basic frame, beat during EMIT held off, abort with a beat offered
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, rdy);
      chk("tbl_ready", FW'(rdy), FW'(tbl[i].exp_rdy));
      chk("tbl_valid", FW'(data_valid), FW'(tbl[i].exp_dv));
      chk("tbl_cnt", FW'(beat_cnt), FW'(tbl[i].exp_cnt));
      chk("tbl_out", data_out, tbl[i].exp_out);
    end

    // One-hot frames: argmax of the packed frame must be the hot slot
    for (int p = 0; p < N; p++) begin
      int idx;
      logic [DW-1:0] best;
      for (int k = 0; k < N; k++) step(1'b1, (k == p) ? 16'd1 : 16'd0, 1'b0, rdy);
      idx = 0;
      best = data_out[DW-1:0];
      for (int k = 1; k < N; k++) begin
        if (data_out[k*DW +: DW] > best) begin
          best = data_out[k*DW +: DW];
          idx = k;
        end
      end
      chk("onehot_argmax", FW'(idx), FW'(p));
      step(1'b0, '0, 1'b0, rdy);
    end

    // Stalled producer: 3 idle cycles between beats
    pulses.delete();
    for (int k = 0; k < N; k++) begin
      step(1'b1, DW'(16'h1000 + k), 1'b0, rdy);
      repeat (3) step(1'b0, 16'hdead, 1'b0, rdy);
    end
    chk("stall_pulses", FW'(pulses.size()), FW'(1));
    chk("stall_frame", data_out, {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000});

    // Back-to-back: 10 beats with valid held high, second beat 5 waits out EMIT
    begin
      int b;
      int guard;
      b = 0;
      guard = 0;
      pulses.delete();
      while (b < 10 && guard < 30) begin
        step(1'b1, DW'(b), 1'b0, rdy);
        if (rdy) b++;
        guard++;
      end
      chk("b2b_beats", FW'(b), FW'(10));
      chk("b2b_pulses", FW'(pulses.size()), FW'(2));
      if (pulses.size() == 2) chk("b2b_spacing", FW'(pulses[1] - pulses[0]), FW'(6));
      chk("b2b_frame2", data_out, {16'd9, 16'd8, 16'd7, 16'd6, 16'd5});
      step(1'b0, '0, 1'b0, rdy);
    end

    // Abort after 3 beats; the beat in the clear cycle is dropped
    pulses.delete();
    repeat (3) step(1'b1, 16'hAAAA, 1'b0, rdy);
    step(1'b1, 16'hAAAA, 1'b1, rdy);
    chk("abort_cnt", FW'(beat_cnt), FW'(0));
    for (int k = 1; k <= N; k++) step(1'b1, DW'(k), 1'b0, rdy);
    chk("abort_pulses", FW'(pulses.size()), FW'(1));
    chk("abort_frame", data_out, f12345);
    step(1'b0, '0, 1'b0, rdy);

    // Async reset mid-frame: outputs clear before any edge
    step(1'b1, 16'h0011, 1'b0, rdy);
    step(1'b1, 16'h0022, 1'b0, rdy);
    rst_n = 1'b0;
    #1;
    chk("arst_out", data_out, '0);
    chk("arst_valid", FW'(data_valid), FW'(0));
    chk("arst_cnt", FW'(beat_cnt), FW'(0));
    chk("arst_ready", FW'(neuron_ready), FW'(0));
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) step(1'b1, DW'(16'h0100 + k), 1'b0, rdy);
    chk("arst_frame", data_out, {16'h0104, 16'h0103, 16'h0102, 16'h0101, 16'h0100});

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 19) == 0), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
